// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// Latency: none (wiring only).
// Backpressure: none; the issuing stage stalls on busy.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               kill;
  logic [2:0]         op;
  logic [WIDTH-1:0]   data0;
  logic [WIDTH-1:0]   data1;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [2*WIDTH-1:0] mul_res;

  // Issuing side: EX stage / pipeline control.
  modport master (
    output start, kill, op, data0, data1,
    input  busy, done, result, mul_res
  );

  // Execution side: the sequencer itself.
  modport slave (
    input  start, kill, op, data0, data1,
    output busy, done, result, mul_res
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div: radix-2 shift-add multiply, restoring divide, sign fix-up.
// Latency: WIDTH+2 cycles from accepted start to done; with MULDIV_EARLY_OUT_EN, trivial ops finish in 1.
// Backpressure: none; starts are only sampled in IDLE, the EX stage stalls while busy is high.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic               neg_res;   // operand signs differ: negate product / quotient
  logic               neg_rem;   // dividend negative: negate remainder
  logic               div_zero;
  logic [WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0] mul_res_q;

  // Operand decode: which operands are interpreted as signed for this op.
  logic             is_div, sgn0, sgn1, accept;
  logic [WIDTH-1:0] mag0, mag1;
  assign is_div = bus.op[2];
  assign sgn0   = bus.data0[WIDTH-1] && (bus.op != 3'b011) && (bus.op != 3'b101) && (bus.op != 3'b111);
  assign sgn1   = bus.data1[WIDTH-1] && (bus.op == 3'b000 || bus.op == 3'b001 ||
                                         bus.op == 3'b100 || bus.op == 3'b110);
  assign mag0   = sgn0 ? -bus.data0 : bus.data0;
  assign mag1   = sgn1 ? -bus.data1 : bus.data1;
  assign accept = (state == IDLE) && bus.start && !bus.kill;

  // Trivial ops whose answer is known at issue time.
  logic             early;
  logic [WIDTH-1:0] early_result;
`ifdef MULDIV_EARLY_OUT_EN
  logic div0_in, ovf_in;
  assign div0_in      = (bus.data1 == '0);
  assign ovf_in       = (bus.op == 3'b100 || bus.op == 3'b110) &&
                        (bus.data0 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data1 == '1);
  assign early        = is_div ? (div0_in || ovf_in) : (bus.data0 == '0 || bus.data1 == '0);
  assign early_result = !is_div ? '0 :
                        ovf_in  ? (bus.op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}}) :
                                  (bus.op[1] ? bus.data0 : '1);
`else
  assign early        = 1'b0;
  assign early_result = '0;
`endif

  // One iteration step: add-and-shift for multiply, trial-subtract for divide.
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] calc_nxt;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign calc_nxt  = !op_q[2] ? (acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]}) :
                     (!div_trial[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                        : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0});

  // Sign fix-up and result selection; divide by zero forces an all-ones quotient.
  logic [2*WIDTH-1:0] prod, fix_mul;
  logic [WIDTH-1:0]   quo, rem, fix_result;
  assign prod       = neg_res ? -acc : acc;
  assign quo        = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem        = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fix_result = op_q[2] ? (op_q[1] ? rem : quo)
                              : ((op_q == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  assign fix_mul    = op_q[2] ? '0 : prod;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; kill returns any active op to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early ? DONE : CALC;
      CALC: if (bus.kill) state_nxt = IDLE;
            else if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = bus.kill ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch magnitudes at issue, iterate in CALC, publish results out of FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      op_q      <= '0;
      opnd      <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      result_q  <= '0;
      mul_res_q <= '0;
    end else if (accept) begin
      op_q     <= bus.op;
      opnd     <= is_div ? mag1 : mag0;
      acc      <= {{WIDTH{1'b0}}, (is_div ? mag0 : mag1)};
      neg_res  <= sgn0 ^ sgn1;
      neg_rem  <= sgn0;
      div_zero <= (bus.data1 == '0);
      cnt      <= CW'(WIDTH - 1);
      if (early) begin
        result_q  <= early_result;
        mul_res_q <= '0;
      end
    end else if (state == CALC) begin
      acc <= calc_nxt;
      cnt <= cnt - CW'(1);
    end else if (state == FIX && !bus.kill) begin
      result_q  <= fix_result;
      mul_res_q <= fix_mul;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.result  = result_q;
  assign bus.mul_res = mul_res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M vectors, latency, kill and async reset.
// Define MULDIV_EARLY_OUT_EN for both bench and RTL to expect the early-out latency.
module tb_muldiv_seq;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LS = 1;
`else
  localparam int LS = 34;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for done within a bounded window, check latency, busy span and results.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] exp_res,
                        input logic [63:0] exp_mul, input int exp_lat);
    int lat, busy_cnt;
    logic got_done;
    @(negedge clk);
    bus.op = op; bus.data0 = d0; bus.data1 = d1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.data0 = $urandom; bus.data1 = $urandom;
    busy_cnt = 0; got_done = 1'b0; lat = 1;
    for (int i = 1; i <= 100; i++) begin
      lat = i;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " done"}, 64'(got_done), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " result"}, 64'(bus.result), 64'(exp_res));
    check({tag, " mul_res"}, bus.mul_res, exp_mul);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    check({tag, " result hold"}, 64'(bus.result), 64'(exp_res));
  endtask

  initial begin
    logic [31:0] prev;
    logic        seen_done, busy_before;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.data0 = '0; bus.data1 = '0;

    // Reset state
    #12;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset mul_res", bus.mul_res, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Special cases
    run_op("DIV 5/0",       3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 64'd0, LS);
    run_op("REMU 5/0",      3'b111, 32'd5,          32'd0,          32'd5,         64'd0, LS);
    run_op("DIV ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 64'd0, LS);
    run_op("REM ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         64'd0, LS);
    run_op("DIVU 7/0",      3'b101, 32'd7,          32'd0,          32'hFFFF_FFFF, 64'd0, LS);
    run_op("REM -7/0",      3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 64'd0, LS);
    run_op("MUL 0x5",       3'b000, 32'd0,          32'd5,          32'd0,         64'd0, LS);

    // High-half multiplies
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001, 34);
    run_op("MULH",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0001, 34);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 34);

    // Divides
    run_op("DIV -20/6",  3'b100, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 64'd0, 34);
    run_op("REM -20/6",  3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 64'd0, 34);
    run_op("DIV 20/-6",  3'b100, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 64'd0, 34);
    run_op("REM 20/-6",  3'b110, 32'd20,        32'hFFFF_FFFA, 32'd2,         64'd0, 34);
    run_op("REMU 20/6",  3'b111, 32'd20,        32'd6,         32'd2,         64'd0, 34);
    run_op("DIVU 20/6",  3'b101, 32'd20,        32'd6,         32'd3,         64'd0, 34);

    // Kill mid-CALC; a start while busy must not be queued
    prev = 32'd3;
    @(negedge clk);
    bus.op = 3'b101; bus.data0 = 32'd100; bus.data1 = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_before = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.data0 = 32'd3; bus.data1 = 32'd3;
      end
      if (c == 6) bus.start = 1'b0;
      if (c == 10) begin
        busy_before = bus.busy;
        bus.kill = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.kill = 1'b0;
    check("kill busy before", 64'(busy_before), 64'd1);
    check("kill busy after", 64'(bus.busy), 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check("kill no done", 64'(seen_done), 64'd0);
    check("kill result", 64'(bus.result), 64'(prev));

    // Reference multiply, leaves nonzero outputs behind
    run_op("MUL 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, 34);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    bus.op = 3'b000; bus.data0 = 32'd5; bus.data1 = 32'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst busy", 64'(bus.busy), 64'd0);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst result", 64'(bus.result), 64'd0);
    check("arst mul_res", bus.mul_res, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("MUL 3x4", 3'b000, 32'd3, 32'd4, 32'd12, 64'd12, 34);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
